// File: rtl/alarm_clk_tick_ctrl_if.sv
// Avalon-MM bus between the tick controller (master) and the
// alarm_clk interval timer (slave).
interface alarm_clk_tick_ctrl_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_irq
    );
endinterface

// File: rtl/alarm_clk_tick_ctrl.sv
// Sequences the interval timer, turns its timeouts into an HH:MM:SS
// time of day and raises a sticky alarm at a programmed HH:MM:00.
module alarm_clk_tick_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 10000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    alarm_clk_tick_ctrl_if.master tmr,
    input  logic       time_set,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic       alarm_set,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       sec_pulse,
    output logic       alarm_o
);

    localparam int TW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        WAIT,
        CLR,
        GAP,
        DIS
    } state_t;

    state_t        state;
    logic [2:0]    addr_q;
    logic          cs_q;
    logic          wr_n_q;
    logic [15:0]   wdata_q;
    logic [TW-1:0] tick_cnt;
    logic [4:0]    al_hh;
    logic [5:0]    al_mm;

    logic       tick;
    logic       sec_adv;
    logic       trig;
    logic [4:0] hh_nx;
    logic [5:0] mm_nx;
    logic [5:0] ss_nx;
    logic [4:0] set_hh_c;
    logic [5:0] set_mm_c;
    logic [4:0] alarm_hh_c;
    logic [5:0] alarm_mm_c;

    assign tmr.tmr_address    = addr_q;
    assign tmr.tmr_chipselect = cs_q;
    assign tmr.tmr_write_n    = wr_n_q;
    assign tmr.tmr_writedata  = wdata_q;

    // A tick is counted on the edge that leaves CLR.
    assign tick    = (state == CLR);
    assign sec_adv = tick && (tick_cnt == TICK_LAST) && !time_set;

    assign set_hh_c   = (set_hh > 5'd23) ? 5'd23 : set_hh;
    assign set_mm_c   = (set_mm > 6'd59) ? 6'd59 : set_mm;
    assign alarm_hh_c = (alarm_hh > 5'd23) ? 5'd23 : alarm_hh;
    assign alarm_mm_c = (alarm_mm > 6'd59) ? 6'd59 : alarm_mm;

    // Time of day one second ahead of the current value, with carries.
    always_comb begin
        ss_nx = ss + 6'd1;
        mm_nx = mm;
        hh_nx = hh;
        if (ss == 6'd59) begin
            ss_nx = 6'd0;
            mm_nx = mm + 6'd1;
            if (mm == 6'd59) begin
                mm_nx = 6'd0;
                hh_nx = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
            end
        end
    end

    assign trig = sec_adv && alarm_en && (ss_nx == 6'd0)
               && (mm_nx == al_mm) && (hh_nx == al_hh);

    // Bus sequencer; write strobes are registered alongside the state
    // so each write is visible exactly during CFG, CLR or DIS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= 3'd0;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
            wdata_q <= 16'd0;
        end else begin
            addr_q  <= 3'd0;
            cs_q    <= 1'b0;
            wr_n_q  <= 1'b1;
            wdata_q <= 16'd0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= CFG;
                        addr_q  <= 3'd1;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        wdata_q <= 16'h0001;
                    end
                end
                CFG: state <= WAIT;
                WAIT: begin
                    if (!enable) begin
                        state   <= DIS;
                        addr_q  <= 3'd1;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        wdata_q <= 16'h0000;
                    end else if (tmr.tmr_irq) begin
                        state   <= CLR;
                        addr_q  <= 3'd0;
                        cs_q    <= 1'b1;
                        wr_n_q  <= 1'b0;
                        wdata_q <= 16'h0000;
                    end
                end
                CLR:  state <= GAP;
                GAP:  state <= WAIT;
                DIS:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tick prescaler and HH:MM:SS counters; a time load beats a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            hh        <= 5'd0;
            mm        <= 6'd0;
            ss        <= 6'd0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            if (time_set) begin
                hh       <= set_hh_c;
                mm       <= set_mm_c;
                ss       <= 6'd0;
                tick_cnt <= '0;
            end else if (tick) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt  <= '0;
                    hh        <= hh_nx;
                    mm        <= mm_nx;
                    ss        <= ss_nx;
                    sec_pulse <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    // Latched alarm time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            al_hh <= 5'd0;
            al_mm <= 6'd0;
        end else if (alarm_set) begin
            al_hh <= alarm_hh_c;
            al_mm <= alarm_mm_c;
        end
    end

    // Sticky alarm flag; a trigger outranks a simultaneous ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_o <= 1'b0;
        end else if (!alarm_en) begin
            alarm_o <= 1'b0;
        end else if (trig) begin
            alarm_o <= 1'b1;
        end else if (alarm_ack) begin
            alarm_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alarm_clk_tick_ctrl.sv
// Bench for alarm_clk_tick_ctrl: timer BFM on the Avalon bus plus a
// seconds-of-day reference model checked every cycle.
module tb_alarm_clk_tick_ctrl;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       time_set;
    logic [4:0] set_hh;
    logic [5:0] set_mm;
    logic       alarm_set;
    logic [4:0] alarm_hh;
    logic [5:0] alarm_mm;
    logic       alarm_en;
    logic       alarm_ack;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       sec_pulse;
    logic       alarm_o;

    alarm_clk_tick_ctrl_if bus ();

    alarm_clk_tick_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .tmr       (bus),
        .time_set  (time_set),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .alarm_set (alarm_set),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_en  (alarm_en),
        .alarm_ack (alarm_ack),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .sec_pulse (sec_pulse),
        .alarm_o   (alarm_o)
    );

    always #5 clk = ~clk;

    // Timer BFM: random timeout period, sticky timeout until status write.
    logic        ie;
    logic        to;
    int unsigned tcnt;
    int unsigned tper;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie   <= 1'b0;
            to   <= 1'b0;
            tcnt <= 0;
            tper <= 8;
        end else begin
            if (tcnt >= tper) begin
                tcnt <= 0;
                tper <= 8 + $urandom_range(0, 12);
                to   <= 1'b1;
            end else begin
                tcnt <= tcnt + 1;
            end
            if (bus.tmr_chipselect && !bus.tmr_write_n) begin
                if (bus.tmr_address == 3'd1) ie <= bus.tmr_writedata[0];
                if (bus.tmr_address == 3'd0) to <= 1'b0;
            end
        end
    end

    assign bus.tmr_irq = to & ie;

    int vecs = 0;
    int errs = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    int tod = 0;
    int tk  = 0;
    int al  = 0;
    bit e_pulse = 0;
    bit e_al    = 0;

    // Bus activity counters.
    int n_sw = 0;
    int n_cfg = 0;
    int n_dis = 0;
    int n_bad = 0;
    int n_pulse = 0;
    bit prev_cs = 0;

    // Inputs to apply at the next negedge.
    bit       d_en = 0;
    bit       d_aen = 0;
    bit       d_ts = 0;
    bit [4:0] d_sh = 0;
    bit [5:0] d_sm = 0;
    bit       d_as = 0;
    bit [4:0] d_ahh = 0;
    bit [5:0] d_amm = 0;
    bit       d_ack = 0;
    bit       auto_ack = 0;
    bit       rst_on_clr = 0;

    function automatic logic [16:0] tod_vec(int t);
        return {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
    endfunction

    task automatic cyc();
        bit sw;
        bit trig;
        int h;
        int m;
        sw = 0;
        @(negedge clk);
        chk("time", {hh, mm, ss}, tod_vec(tod));
        chk("sec_pulse", sec_pulse, e_pulse);
        chk("alarm_o", alarm_o, e_al);
        if (bus.tmr_chipselect) begin
            chk("write_n", bus.tmr_write_n, 0);
            chk("back2back", prev_cs, 0);
            if (bus.tmr_address == 3'd0 && bus.tmr_writedata == 16'h0) begin
                sw = 1;
                n_sw++;
                chk("irq_at_clr", bus.tmr_irq, 1);
            end else if (bus.tmr_address == 3'd1 && bus.tmr_writedata == 16'h1) begin
                n_cfg++;
            end else if (bus.tmr_address == 3'd1 && bus.tmr_writedata == 16'h0) begin
                n_dis++;
            end else begin
                n_bad++;
            end
        end else begin
            chk("idle_bus",
                {bus.tmr_write_n, bus.tmr_address, bus.tmr_writedata},
                {1'b1, 3'd0, 16'd0});
        end
        prev_cs = bus.tmr_chipselect;
        if (sec_pulse) n_pulse++;
        if (rst_on_clr && sw) begin
            reset_n = 1'b0;
            #1;
            chk("rst_cs", bus.tmr_chipselect, 0);
            chk("rst_wr_n", bus.tmr_write_n, 1);
            chk("rst_time", {hh, mm, ss}, 0);
            rst_on_clr = 0;
            prev_cs = 0;
        end
        if (auto_ack && sw && tk == TPS - 1) begin
            d_ack = 1;
            auto_ack = 0;
        end
        enable    = d_en;
        alarm_en  = d_aen;
        time_set  = d_ts;
        set_hh    = d_sh;
        set_mm    = d_sm;
        alarm_set = d_as;
        alarm_hh  = d_ahh;
        alarm_mm  = d_amm;
        alarm_ack = d_ack;
        if (!reset_n) begin
            tod = 0;
            tk = 0;
            al = 0;
            e_pulse = 0;
            e_al = 0;
        end else begin
            trig = 0;
            e_pulse = 0;
            if (d_ts) begin
                h = (d_sh > 23) ? 23 : int'(d_sh);
                m = (d_sm > 59) ? 59 : int'(d_sm);
                tod = h * 3600 + m * 60;
                tk = 0;
            end else if (sw) begin
                tk++;
                if (tk == TPS) begin
                    tk = 0;
                    tod = (tod + 1) % 86400;
                    e_pulse = 1;
                    trig = (tod == al) && d_aen;
                end
            end
            if (d_as) al = int'(d_ahh) * 3600 + int'(d_amm) * 60;
            if (!d_aen) e_al = 0;
            else if (trig) e_al = 1;
            else if (d_ack) e_al = 0;
        end
        d_ts = 0;
        d_as = 0;
        d_ack = 0;
    endtask

    // Run until n more status writes are seen, then one cycle more.
    task automatic run_sw(int n, int bound);
        int target;
        int c;
        target = n_sw + n;
        c = 0;
        while (n_sw < target && c < bound) begin
            cyc();
            c++;
        end
        chk("sw_bound", n_sw >= target, 1);
        cyc();
    endtask

    task automatic set_time(int h, int m);
        d_ts = 1;
        d_sh = 5'(h);
        d_sm = 6'(m);
        cyc();
    endtask

    int base;

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        time_set  = 1'b0;
        set_hh    = '0;
        set_mm    = '0;
        alarm_set = 1'b0;
        alarm_hh  = '0;
        alarm_mm  = '0;
        alarm_en  = 1'b0;
        alarm_ack = 1'b0;

        // Reset state, then enable -> single configuration write.
        repeat (3) cyc();
        chk("rst_cs_idle", bus.tmr_chipselect, 0);
        d_en = 1;
        cyc();
        reset_n = 1'b1;
        repeat (2) cyc();
        chk("cfg_time", n_cfg, 1);
        repeat (6) cyc();
        chk("cfg_once", n_cfg, 1);
        chk("ie_set", ie, 1);

        // Four ticks make one second with a single pulse.
        set_time(0, 0);
        n_pulse = 0;
        run_sw(4, 200);
        chk("ss_one", ss, 1);
        chk("one_pulse", n_pulse, 1);

        // Full-day rollover.
        set_time(23, 59);
        run_sw(240, 20000);
        chk("rollover", {hh, mm, ss}, 0);

        // Alarm at 00:01.
        d_as = 1;
        d_ahh = 0;
        d_amm = 1;
        d_aen = 1;
        cyc();
        set_time(0, 0);
        run_sw(59 * TPS, 20000);
        chk("ss_59", ss, 59);
        chk("no_alarm_yet", alarm_o, 0);
        run_sw(TPS, 200);
        chk("alarm_hit", alarm_o, 1);
        chk("alarm_pulse", sec_pulse, 1);
        d_ack = 1;
        cyc();
        cyc();
        chk("alarm_acked", alarm_o, 0);

        // Ack coincident with trigger, then alarm_en drop.
        d_as = 1;
        d_ahh = 0;
        d_amm = 2;
        cyc();
        set_time(0, 1);
        run_sw(59 * TPS, 20000);
        auto_ack = 1;
        run_sw(TPS, 200);
        chk("ack_used", auto_ack, 0);
        chk("ack_vs_trig", alarm_o, 1);
        d_aen = 0;
        cyc();
        cyc();
        chk("aen_clear", alarm_o, 0);

        // Out-of-range load clamps.
        set_time(31, 63);
        cyc();
        chk("clamp", {hh, mm}, {5'd23, 6'd59});

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                d_ts = 1;
                d_sh = 5'($urandom_range(0, 31));
                d_sm = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 149) == 0) begin
                base = (tod / 60 + 1) % 1440;
                d_as = 1;
                d_ahh = 5'(base / 60);
                d_amm = 6'(base % 60);
            end
            if ($urandom_range(0, 19) == 0) d_ack = 1;
            if ($urandom_range(0, 99) == 0) d_aen = !d_aen;
            if ($urandom_range(0, 149) == 0) d_en = !d_en;
            cyc();
        end

        // enable low in WAIT -> one disable write, then silence.
        d_en = 1;
        d_aen = 0;
        run_sw(1, 500);
        cyc();
        base = n_dis;
        d_en = 0;
        repeat (6) cyc();
        chk("dis_write", n_dis - base, 1);
        base = n_sw;
        repeat (40) cyc();
        chk("quiet_sw", n_sw - base, 0);
        chk("irq_masked", bus.tmr_irq, 0);

        // Re-enable, then reset during CLR.
        base = n_cfg;
        d_en = 1;
        repeat (4) cyc();
        chk("recfg", n_cfg - base, 1);
        set_time(12, 34);
        rst_on_clr = 1;
        for (int i = 0; i < 500 && rst_on_clr; i++) cyc();
        chk("rst_hit", rst_on_clr, 0);
        repeat (3) cyc();
        base = n_cfg;
        reset_n = 1'b1;
        repeat (4) cyc();
        chk("cfg_after_rst", n_cfg - base, 1);
        run_sw(TPS, 500);
        chk("run_after_rst", ss, 1);

        chk("bad_writes", n_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
